eth_tx_frame_arbiter: RTL and testbench

- Frame-level arbiter in the tx_clk domain. Shares the 8-bit MAC TX AXI-stream input among PORTS requesters, e.g. the TX FIFO output, a pause-frame generator and a test-frame source.
- Grants one source per frame using round-robin order and holds the grant until that source's tlast beat.
- Enforces a maximum frame length. Overlong frames are truncated and marked bad, and the rest of that frame is drained from the source.

---
 rtl/eth_tx_arb_pkg.sv | 13 +
 rtl/eth_rr_arbiter.sv | 46 ++++
 rtl/eth_tx_frame_arbiter.sv | 156 +++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and widths for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;
    localparam int GRANT_W    = 3;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin picker: scans rr_last+1, rr_last+2, ... modulo
// PORTS and returns the first requesting port. With prio0_en set, port 0 wins
// whenever it requests.
module eth_rr_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]   req,
    input  logic [GRANT_W-1:0] rr_last,
    input  logic               prio0_en,
    output logic [GRANT_W-1:0] grant,
    output logic               grant_vld
);

    logic [7:0]         req_pad;
    logic [GRANT_W-1:0] cand;

    function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] last,
                                                    input int step);
        int s;
        s = (int'(last) + step) % PORTS;
        return GRANT_W'(s);
    endfunction

    // Pick the first requester after rr_last in circular order, then let port 0 override.
    always_comb begin
        req_pad            = '0;
        req_pad[PORTS-1:0] = req;
        cand               = '0;
        grant              = '0;
        grant_vld          = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = next_idx(rr_last, i);
            if (!grant_vld && req_pad[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
        if (prio0_en && req_pad[0]) begin
            grant     = '0;
            grant_vld = 1'b1;
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level arbiter sharing the MAC TX AXI-stream among PORTS sources.
// One source is granted per frame (round robin), frames longer than
// MAX_FRAME_LEN are truncated with tlast/tuser forced and the remainder drained.
// Optional macro ETH_TX_ARB_PRIO0_EN gives port 0 strict priority in IDLE.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS         = 2,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst,
    input  logic [8*PORTS-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]     s_axis_tvalid,
    output logic [PORTS-1:0]     s_axis_tready,
    input  logic [PORTS-1:0]     s_axis_tlast,
    input  logic [PORTS-1:0]     s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [GRANT_W-1:0]   grant_idx,
    output logic                 busy,
    output logic                 oversize_pulse
);

`ifdef ETH_TX_ARB_PRIO0_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    localparam logic [BEAT_CNT_W-1:0] LIMIT_CNT = BEAT_CNT_W'(MAX_FRAME_LEN - 1);
    localparam logic [GRANT_W-1:0]    LAST_PORT = GRANT_W'(PORTS - 1);

    arb_state_t              state, state_nxt;
    logic [GRANT_W-1:0]      rr_last;
    logic [GRANT_W-1:0]      pick_idx;
    logic                    pick_vld;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [7:0]              sel_data;
    logic                    sel_valid, sel_last, sel_user;
    logic [PORTS-1:0]        grant_mask;
    logic                    at_limit;
    logic                    load_grant, beat_done, frame_end, oversize_hit;

    eth_rr_arbiter #(.PORTS(PORTS)) u_rr (
        .req       (s_axis_tvalid),
        .rr_last   (rr_last),
        .prio0_en  (PRIO0_EN),
        .grant     (pick_idx),
        .grant_vld (pick_vld)
    );

    // The next beat would be beat MAX_FRAME_LEN of the frame.
    assign at_limit = (beat_cnt == LIMIT_CNT);

    // Select the granted port's stream and build its one-hot ready mask.
    always_comb begin
        sel_data   = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_user   = 1'b0;
        grant_mask = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_idx == GRANT_W'(i)) begin
                sel_data      = s_axis_tdata[8*i +: 8];
                sel_valid     = s_axis_tvalid[i];
                sel_last      = s_axis_tlast[i];
                sel_user      = s_axis_tuser[i];
                grant_mask[i] = 1'b1;
            end
        end
    end

    // Next-state logic and the combinational output mux; outputs idle at zero outside XFER.
    always_comb begin
        state_nxt     = state;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        load_grant    = 1'b0;
        beat_done     = 1'b0;
        frame_end     = 1'b0;
        oversize_hit  = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load_grant = 1'b1;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                m_axis_tlast  = sel_last;
                m_axis_tuser  = sel_user;
                s_axis_tready = grant_mask & {PORTS{m_axis_tready}};
                // Last allowed beat without a source tlast: cut the frame here and mark it bad.
                if (at_limit && !sel_last) begin
                    m_axis_tlast = 1'b1;
                    m_axis_tuser = 1'b1;
                end
                if (sel_valid && m_axis_tready) begin
                    beat_done = 1'b1;
                    if (sel_last) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end else if (at_limit) begin
                        oversize_hit = 1'b1;
                        state_nxt    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_axis_tready = grant_mask;
                if (sel_valid && sel_last) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant, round-robin pointer, beat counter and truncation pulse.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            grant_idx      <= '0;
            rr_last        <= LAST_PORT;
            beat_cnt       <= '0;
            oversize_pulse <= 1'b0;
        end else begin
            oversize_pulse <= oversize_hit;
            if (load_grant) grant_idx <= pick_idx;
            if (frame_end) begin
                beat_cnt <= '0;
                // Priority grants of port 0 leave the rotation among the others untouched.
                if (!(PRIO0_EN && grant_idx == '0)) rr_last <= grant_idx;
            end else if (beat_done) begin
                beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter (PORTS=3, MAX_FRAME_LEN=100).
// Source beats carry {port[1:0], beat_index[5:0]} so order and origin can be checked.
module tb_eth_tx_frame_arbiter;

    localparam int NP     = 3;
    localparam int MAXLEN = 100;

    logic              tx_clk = 1'b0;
    logic              tx_rst;
    logic [8*NP-1:0]   s_axis_tdata;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tuser;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic [2:0]        grant_idx;
    logic              busy;
    logic              oversize_pulse;

    eth_tx_frame_arbiter #(.PORTS(NP), .MAX_FRAME_LEN(MAXLEN)) dut (
        .tx_clk         (tx_clk),
        .tx_rst         (tx_rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .grant_idx      (grant_idx),
        .busy           (busy),
        .oversize_pulse (oversize_pulse)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        int port;
        int flen;
        bit fuser;
        int exp_beats;
        int exp_last;
        bit exp_user;
        int exp_pulses;
        int exp_drain;
    } vec_t;

    vec_t vecs[7];

    int total = 0;
    int bad   = 0;

    // source model
    int frames[NP];
    int len[NP];
    int beat[NP];
    bit user[NP];
    bit fire[NP];
    bit toggle_rdy;

    // output monitor
    int exp_order[16];
    int got_grant[16];
    int mon_frames, mon_beats, beat_in_frame, last_len;
    int data_err, pulse_cnt, drain_cnt, gap_cnt, gap_min, gap_max, mirror_err;
    bit last_user, gap_open, after_last, busy_after_last, mirror_chk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NP; p++) begin
            if (frames[p] > 0) begin
                s_axis_tvalid[p]       = 1'b1;
                s_axis_tdata[8*p +: 8] = {2'(p), 6'(beat[p])};
                s_axis_tlast[p]        = (beat[p] == len[p] - 1);
                s_axis_tuser[p]        = user[p];
            end else begin
                s_axis_tvalid[p]       = 1'b0;
                s_axis_tdata[8*p +: 8] = 8'h00;
                s_axis_tlast[p]        = 1'b0;
                s_axis_tuser[p]        = 1'b0;
            end
        end
    endtask

    task automatic clear_mon();
        mon_frames = 0; mon_beats = 0; beat_in_frame = 0; last_len = 0;
        data_err = 0; pulse_cnt = 0; drain_cnt = 0; gap_cnt = 0;
        gap_min = 1000; gap_max = 0; mirror_err = 0;
        last_user = 1'b0; gap_open = 1'b0; after_last = 1'b0;
        busy_after_last = 1'b0; mirror_chk = 1'b0;
        for (int i = 0; i < 16; i++) got_grant[i] = -1;
    endtask

    task automatic monitor();
        if (after_last) begin
            busy_after_last = busy;
            after_last      = 1'b0;
        end
        if (oversize_pulse) pulse_cnt++;
        for (int p = 0; p < NP; p++) begin
            fire[p] = s_axis_tvalid[p] && s_axis_tready[p];
            if (fire[p] && !m_axis_tvalid) drain_cnt++;
        end
        if (mirror_chk && busy && m_axis_tvalid && s_axis_tready != {2'b00, m_axis_tready})
            mirror_err++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (gap_open) begin
                if (gap_cnt < gap_min) gap_min = gap_cnt;
                if (gap_cnt > gap_max) gap_max = gap_cnt;
                gap_open = 1'b0;
            end
            if (mon_frames < 16 && (int'(m_axis_tdata[7:6]) != exp_order[mon_frames] ||
                                    m_axis_tdata[5:0] != 6'(beat_in_frame)))
                data_err++;
            beat_in_frame++;
            mon_beats++;
            if (m_axis_tlast) begin
                if (mon_frames < 16) got_grant[mon_frames] = int'(grant_idx);
                last_len      = beat_in_frame;
                last_user     = m_axis_tuser;
                mon_frames++;
                beat_in_frame = 0;
                gap_open      = 1'b1;
                gap_cnt       = 0;
                after_last    = 1'b1;
            end
        end else if (gap_open && !m_axis_tvalid) begin
            gap_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge tx_clk);
        monitor();
        @(posedge tx_clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                beat[p]++;
                if (beat[p] == len[p]) begin
                    beat[p] = 0;
                    frames[p]--;
                end
            end
        end
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
        drive_inputs();
    endtask

    function automatic bit sources_done();
        for (int p = 0; p < NP; p++) if (frames[p] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_frames(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(sources_done() && busy == 1'b0)) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
        tick();
    endtask

    initial begin
        // port, len, tuser in | beats out, tlast beat, tuser out, pulses, drained
        vecs[0] = '{0,  64, 1'b0,  64,  64, 1'b0, 0,  0};
        vecs[1] = '{1, 150, 1'b0, 100, 100, 1'b1, 1, 50};
        vecs[2] = '{1,  20, 1'b0,  20,  20, 1'b0, 0,  0};
        vecs[3] = '{2, 100, 1'b0, 100, 100, 1'b0, 0,  0};
        vecs[4] = '{2, 101, 1'b0, 100, 100, 1'b1, 1,  1};
        vecs[5] = '{0,  10, 1'b1,  10,  10, 1'b1, 0,  0};
        vecs[6] = '{2,   1, 1'b0,   1,   1, 1'b0, 0,  0};

        tx_rst        = 1'b1;
        m_axis_tready = 1'b1;
        toggle_rdy    = 1'b0;
        for (int p = 0; p < NP; p++) begin
            frames[p] = 0; len[p] = 1; beat[p] = 0; user[p] = 1'b0; fire[p] = 1'b0;
        end
        drive_inputs();
        clear_mon();

        // reset state
        #12;
        check("rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("rst_m_tlast", int'(m_axis_tlast), 0);
        check("rst_m_tuser", int'(m_axis_tuser), 0);
        check("rst_m_tdata", int'(m_axis_tdata), 0);
        check("rst_s_tready", int'(s_axis_tready), 0);
        check("rst_grant", int'(grant_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulse", int'(oversize_pulse), 0);
        @(negedge tx_clk);
        tx_rst = 1'b0;

        // three ports, three frames each, all requesting continuously
        for (int p = 0; p < NP; p++) begin
            frames[p] = 3; len[p] = 5 + p; user[p] = 1'b0;
        end
`ifdef ETH_TX_ARB_PRIO0_EN
        exp_order[0:8] = '{0, 0, 0, 1, 2, 1, 2, 1, 2};
`else
        exp_order[0:8] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
        drive_inputs();
        clear_mon();
        run_frames("rr_run", 400);
        for (int i = 0; i < 9; i++) check($sformatf("rr_grant%0d", i), got_grant[i], exp_order[i]);
        check("rr_frames", mon_frames, 9);
        check("rr_data_err", data_err, 0);
        check("rr_gap_min", gap_min, 1);
        check("rr_gap_max", gap_max, 1);

        // ports 0 and 1 contend for four frames each
        frames[0] = 4; len[0] = 3; frames[1] = 4; len[1] = 4;
`ifdef ETH_TX_ARB_PRIO0_EN
        exp_order[0:7] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order[0:7] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        drive_inputs();
        clear_mon();
        run_frames("prio_run", 300);
        for (int i = 0; i < 8; i++) check($sformatf("prio_grant%0d", i), got_grant[i], exp_order[i]);
        check("prio_data_err", data_err, 0);

        // single-frame vectors: normal, oversize, exact limit, tuser passthrough
        for (int v = 0; v < 7; v++) begin
            frames[vecs[v].port] = 1;
            len[vecs[v].port]    = vecs[v].flen;
            user[vecs[v].port]   = vecs[v].fuser;
            exp_order[0]         = vecs[v].port;
            drive_inputs();
            clear_mon();
            run_frames($sformatf("vec%0d_run", v), 600);
            check($sformatf("vec%0d_grant", v), got_grant[0], vecs[v].port);
            check($sformatf("vec%0d_frames", v), mon_frames, 1);
            check($sformatf("vec%0d_beats", v), mon_beats, vecs[v].exp_beats);
            check($sformatf("vec%0d_tlast_beat", v), last_len, vecs[v].exp_last);
            check($sformatf("vec%0d_tuser", v), int'(last_user), int'(vecs[v].exp_user));
            check($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
            check($sformatf("vec%0d_drained", v), drain_cnt, vecs[v].exp_drain);
            check($sformatf("vec%0d_data_err", v), data_err, 0);
            check($sformatf("vec%0d_busy_after", v), int'(busy_after_last),
                  (vecs[v].exp_drain > 0) ? 1 : 0);
            user[vecs[v].port] = 1'b0;
        end

        // back-pressure toggling every cycle during a 10-byte frame
        frames[0] = 1; len[0] = 10;
        exp_order[0] = 0;
        drive_inputs();
        clear_mon();
        mirror_chk = 1'b1;
        toggle_rdy = 1'b1;
        run_frames("toggle_run", 200);
        toggle_rdy    = 1'b0;
        m_axis_tready = 1'b1;
        check("toggle_beats", mon_beats, 10);
        check("toggle_tlast_beat", last_len, 10);
        check("toggle_data_err", data_err, 0);
        check("toggle_mirror_err", mirror_err, 0);
        check("toggle_pulses", pulse_cnt, 0);

        // asynchronous reset in the middle of a port 1 frame
        frames[1] = 1; len[1] = 40;
        exp_order[0] = 1;
        drive_inputs();
        clear_mon();
        begin
            int n;
            n = 0;
            while (mon_beats < 20 && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                total++;
                bad++;
                $display("FAIL midrst_reach: timeout, beats=%0d", mon_beats);
            end
        end
        check("midrst_pre_busy", int'(busy), 1);
        check("midrst_pre_grant", int'(grant_idx), 1);
        tx_rst = 1'b1;
        #1;
        check("midrst_m_tvalid", int'(m_axis_tvalid), 0);
        check("midrst_m_tdata", int'(m_axis_tdata), 0);
        check("midrst_s_tready", int'(s_axis_tready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_grant", int'(grant_idx), 0);
        for (int p = 0; p < NP; p++) begin
            frames[p] = 0; beat[p] = 0; user[p] = 1'b0;
        end
        drive_inputs();
        repeat (2) @(posedge tx_clk);
        @(negedge tx_clk);
        tx_rst = 1'b0;

        // contention right after reset starts again from port 0
        for (int p = 0; p < NP; p++) begin
            frames[p] = 1; len[p] = 4;
        end
        exp_order[0:2] = '{0, 1, 2};
        drive_inputs();
        clear_mon();
        run_frames("postrst_run", 200);
        for (int i = 0; i < 3; i++) check($sformatf("postrst_grant%0d", i), got_grant[i], exp_order[i]);
        check("postrst_data_err", data_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
